// File: rtl/tt_ihp_pad_cfg_ctrl.sv
// Runtime pad-mode controller: serially loaded, double-buffered config image
// applied break-before-make through a SAFE_CFG parking interval.
module tt_ihp_pad_cfg_ctrl #(
    parameter int                          N_PADS      = 64,
    parameter int                          CFG_W       = 16,
    parameter logic [N_PADS*CFG_W-1:0]     DEFAULT_CFG = '0,
    parameter logic [N_PADS-1:0]           LOCK_MASK   = '0,
    parameter logic [CFG_W-1:0]            SAFE_CFG    = 16'h0006,
    parameter int                          HOLD_CYC    = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_sdi,
    input  logic                           cfg_shift,
    input  logic                           cfg_latch,
    output logic                           cfg_sdo,
    output logic                           busy,
    output logic                           apply_done,
    output logic [N_PADS*CFG_W-1:0]        pad_cfg
);

    localparam int NW = N_PADS * CFG_W;

    typedef enum logic {
        IDLE,
        SAFE
    } state_e;

    state_e              state_q, state_d;
    logic [NW-1:0]       sr_q, sr_d;
    logic [NW-1:0]       act_q, act_d;
    logic [NW-1:0]       pad_q, pad_d;
    logic [N_PADS-1:0]   mask_q, mask_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                done_q, done_d;
    logic [N_PADS-1:0]   chg;

    always_comb begin
        chg = '0;
        for (int i = 0; i < N_PADS; i++) begin
            chg[i] = !LOCK_MASK[i] &&
                     (sr_q[i*CFG_W +: CFG_W] != act_q[i*CFG_W +: CFG_W]);
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        act_d   = act_q;
        pad_d   = pad_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_latch) begin
                    if (chg == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SAFE;
                        mask_d  = chg;
                        cnt_d   = 8'(HOLD_CYC - 1);
                        for (int i = 0; i < N_PADS; i++) begin
                            if (chg[i]) pad_d[i*CFG_W +: CFG_W] = SAFE_CFG;
                        end
                    end
                end else if (cfg_shift) begin
                    sr_d = {sr_q[NW-2:0], cfg_sdi};
                end
            end
            SAFE: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    // Only parked slices take the new image; all others keep ACT.
                    for (int i = 0; i < N_PADS; i++) begin
                        if (mask_q[i]) begin
                            pad_d[i*CFG_W +: CFG_W] = sr_q[i*CFG_W +: CFG_W];
                            act_d[i*CFG_W +: CFG_W] = sr_q[i*CFG_W +: CFG_W];
                        end
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= DEFAULT_CFG;
            act_q   <= DEFAULT_CFG;
            pad_q   <= DEFAULT_CFG;
            mask_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            act_q   <= act_d;
            pad_q   <= pad_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign cfg_sdo    = sr_q[NW-1];
    assign busy       = (state_q == SAFE);
    assign apply_done = done_q;
    assign pad_cfg    = pad_q;

endmodule

// File: tb/tb_tt_ihp_pad_cfg_ctrl.sv
// Directed bench for tt_ihp_pad_cfg_ctrl: 4 pads x 16 bits, HOLD_CYC=3,
// pad 0 locked.
module tb_tt_ihp_pad_cfg_ctrl;

    localparam int          HOLD = 3;
    localparam logic [63:0] DEF  = 64'h000A_000A_0009_0005;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_sdi, cfg_shift, cfg_latch;
    logic        cfg_sdo, busy, apply_done;
    logic [63:0] pad_cfg;

    int n_cmp = 0;
    int n_err = 0;

    tt_ihp_pad_cfg_ctrl #(
        .N_PADS(4), .CFG_W(16), .DEFAULT_CFG(DEF),
        .LOCK_MASK(4'b0001), .SAFE_CFG(16'h0006), .HOLD_CYC(HOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_sdi(cfg_sdi),
        .cfg_shift(cfg_shift), .cfg_latch(cfg_latch),
        .cfg_sdo(cfg_sdo), .busy(busy), .apply_done(apply_done),
        .pad_cfg(pad_cfg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] img;
        logic        changed;
        logic [63:0] safe_exp;
        logic [63:0] fin_exp;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_in(input logic [63:0] img);
        for (int i = 63; i >= 0; i--) begin
            cfg_sdi   = img[i];
            cfg_shift = 1'b1;
            tick();
        end
        cfg_shift = 1'b0;
        cfg_sdi   = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        shift_in(v.img);
        cfg_latch = 1'b1;
        tick();
        cfg_latch = 1'b0;
        if (v.changed) begin
            for (int k = 0; k < HOLD; k++) begin
                chk($sformatf("v%0d safe pad_cfg c%0d", idx, k), pad_cfg, v.safe_exp);
                chk($sformatf("v%0d busy c%0d", idx, k), 64'(busy), 64'd1);
                chk($sformatf("v%0d done low c%0d", idx, k), 64'(apply_done), 64'd0);
                tick();
            end
        end
        chk($sformatf("v%0d final pad_cfg", idx), pad_cfg, v.fin_exp);
        chk($sformatf("v%0d busy end", idx), 64'(busy), 64'd0);
        chk($sformatf("v%0d apply_done", idx), 64'(apply_done), 64'd1);
        tick();
        chk($sformatf("v%0d done pulse end", idx), 64'(apply_done), 64'd0);
    endtask

    initial begin
        int pulses;
        logic [63:0] rb;

        tbl[0] = '{64'h000B_000A_000A_0005, 1'b1,
                   64'h0006_000A_0006_0005, 64'h000B_000A_000A_0005};
        tbl[1] = '{64'hFFFF_000A_000A_1234, 1'b1,
                   64'h0006_000A_000A_0005, 64'hFFFF_000A_000A_0005};
        tbl[2] = '{64'hFFFF_000A_000A_1234, 1'b0,
                   64'h0, 64'hFFFF_000A_000A_0005};
        tbl[3] = '{64'h000A_000A_0009_0005, 1'b1,
                   64'h0006_000A_0006_0005, 64'h000A_000A_0009_0005};

        cfg_sdi = 1'b0; cfg_shift = 1'b0; cfg_latch = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("reset pad_cfg", pad_cfg, DEF);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset sdo", 64'(cfg_sdo), 64'd0);
        chk("reset done", 64'(apply_done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 4; v++) run_vec(tbl[v], v);

        // Readback of the last image shifted in
        rb = '0;
        for (int i = 63; i >= 0; i--) begin
            rb[i]     = cfg_sdo;
            cfg_sdi   = 1'b0;
            cfg_shift = 1'b1;
            tick();
        end
        cfg_shift = 1'b0;
        chk("readback image", rb, 64'h000A_000A_0009_0005);
        chk("readback emptied sdo", 64'(cfg_sdo), 64'd0);

        // Inputs toggled during SAFE must not disturb SR or queue a latch
        shift_in(64'h1111_2222_3333_4444);
        cfg_latch = 1'b1;
        tick();
        for (int k = 0; k < HOLD; k++) begin
            cfg_sdi   = 1'($urandom_range(0, 1));
            cfg_shift = 1'b1;
            cfg_latch = k[0];
            tick();
        end
        cfg_sdi = 1'b0; cfg_shift = 1'b0; cfg_latch = 1'b0;
        pulses = (apply_done === 1'b1) ? 1 : 0;
        chk("t5 final pad_cfg", pad_cfg, 64'h1111_2222_3333_0005);
        for (int k = 0; k < 6; k++) begin
            tick();
            if (apply_done === 1'b1) pulses++;
            chk($sformatf("t5 idle busy c%0d", k), 64'(busy), 64'd0);
        end
        chk("t5 done pulses", 64'(pulses), 64'd1);

        // Held latch with SR==ACT: done each cycle, no pad activity
        cfg_latch = 1'b1;
        tick();
        chk("hold latch done 1", 64'(apply_done), 64'd1);
        chk("hold latch busy 1", 64'(busy), 64'd0);
        tick();
        chk("hold latch done 2", 64'(apply_done), 64'd1);
        chk("hold latch pad_cfg", pad_cfg, 64'h1111_2222_3333_0005);
        cfg_latch = 1'b0;
        tick();
        chk("hold latch release", 64'(apply_done), 64'd0);

        // Reset in the 2nd SAFE cycle
        shift_in(64'h5555_6666_7777_8888);
        cfg_latch = 1'b1;
        tick();
        cfg_latch = 1'b0;
        chk("t6 safe pad_cfg", pad_cfg, 64'h0006_0006_0006_0005);
        tick();
        chk("t6 busy before rst", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 rst pad_cfg", pad_cfg, DEF);
        chk("t6 rst busy", 64'(busy), 64'd0);
        chk("t6 rst done", 64'(apply_done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (apply_done === 1'b1) pulses++;
        end
        chk("t6 no done after rst", 64'(pulses), 64'd0);
        chk("t6 pad_cfg stays default", pad_cfg, DEF);
        chk("t6 busy stays low", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
